multicycle_alu: RTL

Parametrised, handshaked successor to the single-cycle datapath ALU.
- Logic, shift, add/sub and compare ops: registered, 1-cycle latency.
- Signed/unsigned multiply: iterative shift-add. Signed/unsigned divide: iterative restoring.
- Full 2*XLEN product or quotient/remainder pair returned. Sits in the EX stage; the pipeline stalls on in_ready low.

---
 rtl/multicycle_alu.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Handshaked EX-stage ALU: registered 1-cycle ops plus iterative
// shift-add multiply and restoring divide with a full-width result pair.
module multicycle_alu #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_operation,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic [XLEN-1:0] hi,
    output logic            div_by_zero,
    output logic            negative,
    output logic            zero
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_XOR   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_ADDU  = 4'd9;
    localparam logic [3:0] OP_SUB   = 4'd10;
    localparam logic [3:0] OP_SUBU  = 4'd11;
    localparam logic [3:0] OP_MULT  = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_MULTU = 4'd14;
    localparam logic [3:0] OP_DIVU  = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t              state_q, state_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic                isdiv_q, isdiv_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [XLEN-1:0]     out_q, out_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic                vld_q, vld_d;
    logic                dbz_q, dbz_d;

    logic                accept;
    logic                sgn_op;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [XLEN-1:0]     alu_res;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   mul_nx, div_nx;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;

    assign in_ready = (state_q == IDLE) && !rst
                    && (!vld_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign sgn_op = (alu_operation == OP_MULT)
                 || (alu_operation == OP_DIV);
    assign a_neg  = sgn_op && input1[XLEN-1];
    assign b_neg  = sgn_op && input2[XLEN-1];
    assign a_abs  = a_neg ? -input1 : input1;
    assign b_abs  = b_neg ? -input2 : input2;

    always_comb begin
        alu_res = '0;
        unique case (alu_operation)
            OP_XOR:  alu_res = input1 ^ input2;
            OP_OR:   alu_res = input1 | input2;
            OP_AND:  alu_res = input1 & input2;
            OP_NOR:  alu_res = ~(input1 | input2);
            OP_SLL:  alu_res = input1 << input2[SHW-1:0];
            OP_SRL:  alu_res = input1 >> input2[SHW-1:0];
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                         $signed(input1) < $signed(input2)};
            OP_ADD,
            OP_ADDU: alu_res = input1 + input2;
            OP_SUB,
            OP_SUBU: alu_res = input1 - input2;
            default: alu_res = '0;
        endcase
    end

    // Multiply: add multiplicand into the high half on a set LSB, shift right.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    assign mul_nx  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                              : {1'b0, acc_q[2*XLEN-1:1]};

    // Divide: shift left, trial-subtract divisor, keep on no borrow.
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
    assign div_nx   = div_diff[XLEN]
                    ? {acc_q[2*XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = rneg_q ? -acc_q[2*XLEN-1:XLEN]
                         : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        isdiv_d = isdiv_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        out_d   = out_q;
        hi_d    = hi_q;
        vld_d   = vld_q;
        dbz_d   = dbz_q;
        if (vld_q && out_ready) vld_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (alu_operation)
                        OP_MULT, OP_MULTU: begin
                            acc_d   = {{XLEN{1'b0}}, b_abs};
                            opd_d   = a_abs;
                            neg_d   = a_neg ^ b_neg;
                            isdiv_d = 1'b0;
                            cnt_d   = '0;
                            state_d = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (input2 == '0) begin
                                out_d = '1;
                                hi_d  = input1;
                                dbz_d = 1'b1;
                                vld_d = 1'b1;
                            end else begin
                                acc_d   = {{XLEN{1'b0}}, a_abs};
                                opd_d   = b_abs;
                                neg_d   = a_neg ^ b_neg;
                                rneg_d  = a_neg;
                                isdiv_d = 1'b1;
                                cnt_d   = '0;
                                state_d = DIV;
                            end
                        end
                        default: begin
                            out_d = alu_res;
                            hi_d  = '0;
                            dbz_d = 1'b0;
                            vld_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_nx : div_nx;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN-1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isdiv_q) begin
                    out_d = quo;
                    hi_d  = rem;
                end else begin
                    {hi_d, out_d} = prod;
                end
                dbz_d   = 1'b0;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            isdiv_q <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            vld_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            isdiv_q <= isdiv_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            vld_q   <= vld_d;
            dbz_q   <= dbz_d;
        end
    end

    assign out         = out_q;
    assign hi          = hi_q;
    assign out_valid   = vld_q;
    assign div_by_zero = dbz_q;
    assign negative    = out_q[XLEN-1];
    assign zero        = ~|out_q;

endmodule
